// File: rtl/tag_compare_stage.sv
// tag_compare_stage: way tag compare, hit encode and registered handoff to data-select with hit/miss stats
module tag_compare_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int DOSA = 4,
  parameter int ENCODER_WIDTH = 2,
  parameter int ADDR_WIDTH = 33,
  parameter int TAG_WIDTH = 20,
  parameter int TAG_LSB = 12,
  parameter int CNT_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s1_valid,
  output logic                       s1_ready,
  input  logic [ADDR_WIDTH-1:0]      Address_pe,
  input  logic [TAG_WIDTH*DOSA-1:0]  tag_rd,
  input  logic [DOSA-1:0]            valid_rd,
  input  logic [DATA_WIDTH*DOSA-1:0] data_rd,
  output logic                       s2_valid,
  input  logic                       s3_ready,
  output logic [DATA_WIDTH*DOSA-1:0] Data_x,
  output logic                       HIT,
  output logic                       Rd_Wr,
  output logic [ENCODER_WIDTH-1:0]   hit_encode,
  output logic                       multi_hit_err,
  input  logic                       clr_stats,
  output logic [CNT_WIDTH-1:0]       hit_count,
  output logic [CNT_WIDTH-1:0]       miss_count
);
  logic [DOSA-1:0] match;
  logic [ENCODER_WIDTH-1:0] enc;
  logic hit, multi, acc;
  for (genvar g = 0; g < DOSA; g++) begin : g_way
    assign match[g] = valid_rd[g] && (tag_rd[g*TAG_WIDTH +: TAG_WIDTH] == Address_pe[TAG_LSB +: TAG_WIDTH]);
  end
  always_comb begin
    enc = '0;
    for (int i = DOSA-1; i >= 0; i--) enc = match[i] ? ENCODER_WIDTH'(i) : enc;
  end
  assign hit = |match;
  assign multi = |(match & (match - DOSA'(1)));
  assign s1_ready = !s2_valid || s3_ready;
  assign acc = s1_valid && s1_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      Data_x <= '0;
      HIT <= 1'b0;
      Rd_Wr <= 1'b0;
      hit_encode <= '0;
      multi_hit_err <= 1'b0;
      hit_count <= '0;
      miss_count <= '0;
    end else begin
      s2_valid <= acc || (s2_valid && !s3_ready);
      Data_x <= acc ? data_rd : Data_x;
      HIT <= acc ? hit : HIT;
      Rd_Wr <= acc ? Address_pe[ADDR_WIDTH-1] : Rd_Wr;
      hit_encode <= acc ? enc : hit_encode;
      multi_hit_err <= !clr_stats && (multi_hit_err || (acc && multi));
      hit_count <= clr_stats ? '0 : hit_count + CNT_WIDTH'(acc && hit && !(&hit_count));
      miss_count <= clr_stats ? '0 : miss_count + CNT_WIDTH'(acc && !hit && !(&miss_count));
    end
  end
endmodule
